// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped I/O port.
// Default register addresses and status-register bit positions. The assembler
// and software headers use these same values.
package mmio_pkg;

  localparam int unsigned MMIO_DW = 16;

  localparam logic [15:0] MMIO_IN_ADDR   = 16'hFFF0;
  localparam logic [15:0] MMIO_OUT_ADDR  = 16'hFFF2;
  localparam logic [15:0] MMIO_STAT_ADDR = 16'hFFF4;

  // Status register bit indices
  localparam int unsigned STAT_NEW = 0;
  localparam int unsigned STAT_OVR = 1;

endpackage

// File: rtl/mmio_in_filter.sv
// mmio_in_filter: input path for the board switches.
// Two-flop synchronizer, optional debounce filter and the committed input
// register. 'commit' is high in the cycle whose closing edge loads a new value
// into in_reg, so the parent can set its flags on that same edge.
//
// Build option: MMIO_DEBOUNCE_EN
//   defined   - a value must sit stable in sync2 for DEBOUNCE_CYCLES cycles
//   undefined - in_reg follows sync2 directly (DEBOUNCE_CYCLES unused)
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   fpga_in   - raw, asynchronous switch inputs
//   in_reg    - committed input value
//   commit    - new value lands in in_reg at the next rising edge
module mmio_in_filter
  import mmio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MMIO_DW-1:0] fpga_in,
  output logic [MMIO_DW-1:0] in_reg,
  output logic               commit
);

  logic [MMIO_DW-1:0] sync1_q, sync2_q;
  logic [MMIO_DW-1:0] in_reg_q, in_reg_d;
  logic               commit_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      in_reg_q <= '0;
    end else begin
      sync1_q  <= fpga_in;
      sync2_q  <= sync1_q;
      in_reg_q <= in_reg_d;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [MMIO_DW-1:0] cand_q, cand_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (32'(cnt_q) < DEBOUNCE_CYCLES) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Commit on the edge where the counter steps onto DEBOUNCE_CYCLES-1, i.e.
  // after the candidate has been seen stable for DEBOUNCE_CYCLES samples.
  assign commit_w = (sync2_q == cand_q) && (cand_q != in_reg_q) &&
                    (32'(cnt_q) + 32'd1 >= DEBOUNCE_CYCLES - 32'd1);
  assign in_reg_d = commit_w ? cand_q : in_reg_q;
`else
  assign commit_w = (sync2_q != in_reg_q);
  assign in_reg_d = sync2_q;
`endif

  assign in_reg = in_reg_q;
  assign commit = commit_w;

endmodule

// File: rtl/mmio_port.sv
// mmio_port: memory-mapped I/O port on the data-memory bus.
// Decodes three addresses: a read-only input register fed by the filtered
// board switches, a read/write output register driving the LEDs, and a
// status register (new-data / overrun flags) that clears when loaded.
//
// Build option: MMIO_DEBOUNCE_EN (enables the input debounce filter)
//
// Ports:
//   CLK, reset          - clock, asynchronous active-high reset
//   Addr, WriteData     - bus address and store data
//   MemWrite, MemRead   - one-cycle store / load strobes
//   ReadData            - combinational load data, 0 when not selected
//   IOSel               - Addr hits one of the port registers
//   FPGAIn              - asynchronous switch inputs
//   FPGAOut             - registered LED outputs
module mmio_port
  import mmio_pkg::*;
#(
  parameter logic [15:0] IN_ADDR         = MMIO_IN_ADDR,
  parameter logic [15:0] OUT_ADDR        = MMIO_OUT_ADDR,
  parameter logic [15:0] STAT_ADDR       = MMIO_STAT_ADDR,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] Addr,
  input  logic [15:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [15:0] ReadData,
  output logic        IOSel,
  input  logic [15:0] FPGAIn,
  output logic [15:0] FPGAOut
);

  logic        hit_in, hit_out, hit_stat;
  logic [15:0] in_reg;
  logic        commit;
  logic        new_q, new_d;
  logic        ovr_q, ovr_d;
  logic [15:0] out_q, out_d;
  logic [15:0] stat_word;

  mmio_in_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_in_filter (
    .clk     (CLK),
    .rst     (reset),
    .fpga_in (FPGAIn),
    .in_reg  (in_reg),
    .commit  (commit)
  );

  assign hit_in   = (Addr == IN_ADDR);
  assign hit_out  = (Addr == OUT_ADDR);
  assign hit_stat = (Addr == STAT_ADDR);
  assign IOSel    = hit_in | hit_out | hit_stat;

  // Clear first, then set: a commit on the same edge as a clearing load wins.
  always_comb begin
    new_d = new_q;
    ovr_d = ovr_q;
    out_d = out_q;
    if (MemRead && (hit_in || hit_stat)) new_d = 1'b0;
    if (MemRead && hit_stat)             ovr_d = 1'b0;
    if (commit) begin
      new_d = 1'b1;
      if (new_q) ovr_d = 1'b1;
    end
    if (MemWrite && hit_out) out_d = WriteData;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      new_q <= 1'b0;
      ovr_q <= 1'b0;
      out_q <= '0;
    end else begin
      new_q <= new_d;
      ovr_q <= ovr_d;
      out_q <= out_d;
    end
  end

  always_comb begin
    stat_word           = '0;
    stat_word[STAT_NEW] = new_q;
    stat_word[STAT_OVR] = ovr_q;
  end

  always_comb begin
    ReadData = '0;
    if (hit_in)        ReadData = in_reg;
    else if (hit_out)  ReadData = out_q;
    else if (hit_stat) ReadData = stat_word;
  end

  assign FPGAOut = out_q;

endmodule

// File: tb/tb_mmio_port.sv
module tb_mmio_port;

`ifdef MMIO_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int unsigned DCYC = 4;
  localparam int unsigned LAT  = DEB ? 2 + DCYC : 3;

  localparam int unsigned SEL_RD  = 0;
  localparam int unsigned SEL_OUT = 1;
  localparam int unsigned SEL_IOS = 2;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] Addr, WriteData, FPGAIn;
  logic        MemWrite, MemRead;
  logic [15:0] ReadData, FPGAOut;
  logic        IOSel;

  mmio_port #(
    .DEBOUNCE_CYCLES (DCYC)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .IOSel     (IOSel),
    .FPGAIn    (FPGAIn),
    .FPGAOut   (FPGAOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned cyc;
    int unsigned sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cycle = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        e;
  logic [15:0] act;

  always @(posedge CLK) cycle <= cycle + 1;

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RD:  act = ReadData;
        SEL_OUT: act = FPGAOut;
        default: act = {15'b0, IOSel};
      endcase
      n_checks++;
      if (e.cyc != cycle || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (cycle %0d, queued for %0d)",
                 e.name, act, e.exp, cycle, e.cyc);
      end
    end
  end

  task automatic expect_val(input int unsigned sel, input logic [15:0] exp, input string name);
    exp_t x;
    x.cyc  = cycle;
    x.sel  = sel;
    x.exp  = exp;
    x.name = name;
    sb.push_back(x);
  endtask

  // Advance to just after the next rising edge; strobes default low.
  task automatic step();
    @(posedge CLK);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; FPGAIn = '0; Addr = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    step(); step();
    Addr = 16'hFFF2;
    expect_val(SEL_RD, 16'h0000, "rst_out_rd");
    expect_val(SEL_OUT, 16'h0000, "rst_fpgaout");
    step();
    Addr = 16'hFFF4;
    expect_val(SEL_RD, 16'h0000, "rst_stat");
    expect_val(SEL_IOS, 16'h0001, "rst_iosel_stat");
    step();
    reset = 1'b0;
    Addr  = 16'h1234;
    expect_val(SEL_IOS, 16'h0000, "iosel_miss");
    expect_val(SEL_RD, 16'h0000, "rd_miss");
    step();

    // Input commit latency
    FPGAIn = 16'h13B0;
    Addr   = 16'hFFF0;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      step();
      if (k == int'(LAT) - 1) begin
        Addr = 16'hFFF4; expect_val(SEL_RD, 16'h0000, "t1_stat_pre");
      end else if (k < int'(LAT)) begin
        Addr = 16'hFFF0; expect_val(SEL_RD, 16'h0000, "t1_in_pre");
      end else if (k == int'(LAT)) begin
        Addr = 16'hFFF0; expect_val(SEL_RD, 16'h13B0, "t1_in_commit");
      end else begin
        Addr = 16'hFFF4; expect_val(SEL_RD, 16'h0001, "t1_new_set");
      end
    end
    step(); Addr = 16'hFFF0; MemRead = 1'b1; expect_val(SEL_RD, 16'h13B0, "t1_load_in");
    step(); Addr = 16'hFFF4; MemRead = 1'b1; expect_val(SEL_RD, 16'h0000, "t1_load_stat");

    // Output register
    step(); Addr = 16'hFFF2; MemWrite = 1'b1; WriteData = 16'h000B;
    expect_val(SEL_IOS, 16'h0001, "t2_iosel_store");
    expect_val(SEL_OUT, 16'h0000, "t2_out_pre");
    step(); Addr = 16'hFFF2; MemRead = 1'b1;
    expect_val(SEL_OUT, 16'h000B, "t2_out_post");
    expect_val(SEL_RD, 16'h000B, "t2_load_out");

    // Return input to zero, then a short glitch
    step(); FPGAIn = 16'h0000;
    repeat (LAT + 2) step();
    Addr = 16'hFFF4; MemRead = 1'b1; expect_val(SEL_RD, 16'h0001, "t3_zero_commit");
    step(); FPGAIn = 16'h00FF;
    step(); step(); FPGAIn = 16'h0000;
    repeat (LAT + 4) step();
    Addr = 16'hFFF4; expect_val(SEL_RD, DEB ? 16'h0000 : 16'h0003, "t3_glitch_stat");
    step(); Addr = 16'hFFF0; expect_val(SEL_RD, 16'h0000, "t3_glitch_in");
    step(); Addr = 16'hFFF4; MemRead = 1'b1;
    expect_val(SEL_RD, DEB ? 16'h0000 : 16'h0003, "t3_glitch_clear");
    step(); Addr = 16'hFFF4; expect_val(SEL_RD, 16'h0000, "t3_stat_cleared");

    // Two commits without reading: overrun
    step(); FPGAIn = 16'h0001;
    repeat (LAT + 2) step();
    FPGAIn = 16'h0002;
    repeat (LAT + 2) step();
    Addr = 16'hFFF0; expect_val(SEL_RD, 16'h0002, "t4_in");
    step(); Addr = 16'hFFF4; MemRead = 1'b1; expect_val(SEL_RD, 16'h0003, "t4_ovr_load");
    step(); Addr = 16'hFFF4; MemRead = 1'b1; expect_val(SEL_RD, 16'h0000, "t4_ovr_cleared");

    // Commit on the same edge as a clearing load
    step(); FPGAIn = 16'h0005;
    repeat (LAT - 1) step();
    Addr = 16'hFFF0; MemRead = 1'b1; expect_val(SEL_RD, 16'h0002, "t5_load_old");
    step(); Addr = 16'hFFF4; expect_val(SEL_RD, 16'h0001, "t5_new_kept");
    step(); Addr = 16'hFFF0; expect_val(SEL_RD, 16'h0005, "t5_in_new");
    step(); Addr = 16'hFFF4; MemRead = 1'b1; expect_val(SEL_RD, 16'h0001, "t5_clear");

    // Reset mid-filter, then ignored stores
    step(); Addr = 16'hFFF2; MemWrite = 1'b1; WriteData = 16'hBEEF;
    step(); FPGAIn = 16'h0007; Addr = 16'hFFF2; expect_val(SEL_OUT, 16'hBEEF, "t6_out_beef");
    repeat (LAT - 1) step();
    reset = 1'b1; Addr = 16'hFFF0;
    expect_val(SEL_OUT, 16'h0000, "t6_rst_out");
    expect_val(SEL_RD, 16'h0000, "t6_rst_in");
    step(); step();
    reset = 1'b0; Addr = 16'hFFF0;
    for (int k = 1; k <= int'(LAT); k++) begin
      step();
      expect_val(SEL_RD, (k == int'(LAT)) ? 16'h0007 : 16'h0000, "t6_recommit");
    end
    step(); Addr = 16'hFFF2; MemWrite = 1'b1; WriteData = 16'h00AA;
    step(); Addr = 16'hFFF0; MemWrite = 1'b1; WriteData = 16'h1234;
    expect_val(SEL_IOS, 16'h0001, "t6_iosel_in_wr");
    step(); Addr = 16'hFFF4; MemWrite = 1'b1; WriteData = 16'hFFFF;
    step(); Addr = 16'hFFF2;
    expect_val(SEL_OUT, 16'h00AA, "t6_out_kept");
    expect_val(SEL_RD, 16'h00AA, "t6_load_out");
    step(); Addr = 16'hFFF4; expect_val(SEL_RD, 16'h0001, "t6_stat_after_wr");
    step(); Addr = 16'hFFF0; expect_val(SEL_RD, 16'h0007, "t6_in_after_wr");
    step(); step();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_port.md
# mmio_port

Memory-mapped I/O port for the multicycle processor. It sits on the data-memory bus beside data RAM and is the processor-side end of the board pins. The `FPGAIn` switches are synchronized, filtered and latched into a readable input register with a new-data flag. Processor stores to the output address drive `FPGAOut`, the value the board LEDs show and the system bench checks.

## Interface
Parameters:
- `IN_ADDR`, 16'hFFF0: address of the read-only input register.
- `OUT_ADDR`, 16'hFFF2: address of the read/write output register.
- `STAT_ADDR`, 16'hFFF4: address of the status register; a read clears its flags.
- `DEBOUNCE_CYCLES`, 4: number of consecutive stable cycles before an input value commits. Must be ≥1.

Ports:
- Clock and reset: one clock `CLK`; `reset` is asynchronous and active-high.
- `CLK`, in, 1: system clock; everything samples on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `Addr`, in, 16: bus address.
- `WriteData`, in, 16: store data.
- `MemWrite`, in, 1: store strobe, one cycle.
- `MemRead`, in, 1: load strobe, one cycle; it triggers read side effects.
- `ReadData`, out, 16: combinational load data; 0 when `IOSel` is low.
- `IOSel`, out, 1: combinational; high when `Addr` equals one of the three addresses. The top level uses it to steer the RAM read mux and gate RAM writes.
- `FPGAIn`, in, 16: asynchronous board switches.
- `FPGAOut`, out, 16: registered output to the LEDs.

## Operation
- Input path:
  - `FPGAIn` passes through a 2-flop synchronizer (`sync1`, `sync2`).
  - A filter holds `cand` and a stability counter.
  - When `sync2 != cand`: `cand <= sync2` and the counter is cleared.
  - Otherwise the counter increments, saturating at `DEBOUNCE_CYCLES`.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with `sync2 == cand` and `cand != in_reg`, then `in_reg <= cand` and a commit pulse fires.
- Status flags:
  - A commit sets `new_flag`.
  - A commit while `new_flag` is already set also sets `ovr_flag`.
- Reads:
  - `Addr==IN_ADDR`: returns `in_reg`. A read with `MemRead` clears `new_flag` at the edge.
  - `Addr==STAT_ADDR`: returns {14'b0, `ovr_flag`, `new_flag`}. A read with `MemRead` clears both flags at the edge.
  - `Addr==OUT_ADDR`: returns `FPGAOut`.
- Writes:
  - `MemWrite` with `Addr==OUT_ADDR` loads `FPGAOut <= WriteData`.
  - Writes to `IN_ADDR` or `STAT_ADDR` are ignored. `IOSel` is still high, so RAM is not written either.
- Simultaneous events: a commit in the same cycle as a clearing read leaves the flag set (set wins). The value returned by that read is the pre-edge `in_reg`.
- `MemRead` and `MemWrite` are never both high; no behaviour is defined for that case.

## Timing
- Reset values: `FPGAOut`=0, `in_reg`=0, `sync1`/`sync2`/`cand`=0, counter=0, `new_flag`=0, `ovr_flag`=0. `ReadData` and `IOSel` follow the inputs combinationally.
- Reset asserted mid-filter discards the pending candidate. After release, a stable nonzero `FPGAIn` recommits with full latency.
- Input latency: a value first sampled at edge 1 and held stable is in `in_reg` after edge 2+`DEBOUNCE_CYCLES` (6 by default). `new_flag` is visible on the same edge.
- A pulse shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never commits.
- Output latency: `FPGAOut` updates on the edge that samples the store. The load in the next cycle returns the new value.
- Load data is valid in the same cycle as `Addr`, matching the data-RAM read timing.

## Configuration
- `MMIO_DEBOUNCE_EN` defined: filter as described above.
- `MMIO_DEBOUNCE_EN` undefined:
  - `cand`, the counter and `DEBOUNCE_CYCLES` are unused.
  - `in_reg <= sync2` every cycle; a commit fires when `sync2 != in_reg`.
  - Input latency becomes 3 edges.
  - Flag, read and write behaviour are unchanged.

## Structure
- Package `mmio_pkg`: default address constants (`MMIO_IN_ADDR`, `MMIO_OUT_ADDR`, `MMIO_STAT_ADDR`) and status bit indices (`STAT_NEW`=0, `STAT_OVR`=1). The assembler and software headers use the same values.
- Sub-module `mmio_in_filter`: synchronizer, debounce filter and `in_reg`. It outputs `in_reg` and the commit pulse and carries the `MMIO_DEBOUNCE_EN` split.
- `mmio_port` itself keeps the decode, flags, output register and read mux.

## Test plan
- Reset, then `FPGAIn`=16'h13B0 held → `in_reg`=16'h13B0 and `new_flag`=1 exactly after the 6th edge. Load from FFF0 returns 16'h13B0; a following load from FFF4 returns 16'h0000.
- Store 16'h000B to FFF2 → `FPGAOut`=16'h000B after that edge. A load from FFF2 returns 16'h000B; `IOSel`=1 during the store.
- `FPGAIn` goes 16'h0000→16'h00FF for 2 cycles, then back to 0 → no commit; `new_flag` stays 0.
- Commit 16'h0001, then 16'h0002 without reading → a load from FFF4 returns 16'h0003; the next load from FFF4 returns 16'h0000.
- Commit lands on the same edge as a load from FFF0 → the load returns the old value and `new_flag`=1 after the edge.
- Assert `reset` with 3 filter cycles elapsed and `FPGAOut`=16'hBEEF → `FPGAOut`=0 immediately. After release, the input recommits 6 edges later. Store to FFF0 → `FPGAOut` unchanged.
